// File: rtl/serial_stream_source.sv
// Purpose : parallel-to-serial transmitter; buffers LENGTH-bit words in a DEPTH-entry FIFO
//           and shifts each out MSB-first on a 1-bit valid/ready serial bus, words back-to-back.
// Latency : accept-to-first-bit 2 cycles (FIFO write, then load into shifter); no bubble between queued words.
// Backpr. : i_ready=0 holds o_dout/o_dout_valid; a full FIFO drops o_ready; i_en=0 freezes everything.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-low reset
//   i_en                  global enable; 0 freezes all state and masks o_ready/o_dout_valid
//   iv_din, i_din_valid   parallel word in; accepted when i_din_valid & o_ready
//   o_ready               FIFO can take a word this cycle
//   o_dout, o_dout_valid  serial bit (MSB first) and its valid
//   i_ready               downstream takes the serial bit this cycle
//   ov_words_sent         wrapping count of fully transmitted words
//   o_busy                FIFO non-empty or shifter active
module serial_stream_source #(
    parameter int LENGTH    = 24,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [LENGTH-1:0]    iv_din,
    input  logic                 i_din_valid,
    output logic                 o_ready,
    output logic                 o_dout,
    output logic                 o_dout_valid,
    input  logic                 i_ready,
    output logic [CNT_WIDTH-1:0] ov_words_sent,
    output logic                 o_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int BIT_W = $clog2(LENGTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [LENGTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    state_t            state;
    logic [LENGTH-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic              rst_done;   // low from a reset edge until the first released edge

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic xfer;
    logic last_bit;

    assign full     = (occ == OCC_W'(DEPTH));
    assign empty    = (occ == '0);

    // Full blocks writes even when a pop happens in the same cycle.
    assign o_ready      = i_en & rst_done & ~full;
    assign o_dout_valid = i_en & (state == SHIFT);
    assign o_busy       = ~empty | (state == SHIFT);
    assign o_dout       = shreg[LENGTH-1];

    assign push     = i_din_valid & o_ready;
    assign xfer     = o_dout_valid & i_ready;
    assign last_bit = (bit_cnt == BIT_W'(LENGTH - 1));

    // Pop from IDLE, or on the final bit so the next word follows with no gap.
    // Occupancy is sampled from the register, so a word written this edge is
    // only visible to the pop on the following edge.
    assign pop = i_en & ~empty & ((state == IDLE) | (xfer & last_bit));

    always_ff @(posedge i_clk) begin
        if (i_rst && push) begin
            mem[wr_ptr] <= iv_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            ov_words_sent <= '0;
            rst_done      <= 1'b0;
        end else begin
            rst_done <= 1'b1;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_cnt <= '0;
                state   <= SHIFT;
            end else if (xfer) begin
                shreg   <= {shreg[LENGTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_W'(1);
                if (last_bit) begin
                    state <= IDLE;
                end
            end

            if (xfer && last_bit) begin
                ov_words_sent <= ov_words_sent + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_stream_source.sv
module tb_serial_stream_source;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_en;
    logic [23:0] iv_din;
    logic        i_din_valid;
    logic        o_ready;
    logic        o_dout;
    logic        o_dout_valid;
    logic        i_ready;
    logic [15:0] ov_words_sent;
    logic        o_busy;

    int ntests = 0;
    int nfail  = 0;
    int exp_words = 0;

    always #5 clk = ~clk;

    serial_stream_source #(.LENGTH(24), .DEPTH(4), .CNT_WIDTH(16)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .iv_din       (iv_din),
        .i_din_valid  (i_din_valid),
        .o_ready      (o_ready),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready),
        .ov_words_sent(ov_words_sent),
        .o_busy       (o_busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        i_rst = 1'b0; i_en = 1'b1; iv_din = '0; i_din_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        ntests++;
        if (o_dout_valid !== 1'b0 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_dout !== 1'b0) begin
            nfail++;
            $display("FAIL reset_flags: got valid=%b ready=%b busy=%b dout=%b, expected all 0",
                     o_dout_valid, o_ready, o_busy, o_dout);
        end
        ntests++;
        if (ov_words_sent !== 16'd0) begin
            nfail++;
            $display("FAIL reset_count: got %0d expected 0", ov_words_sent);
        end
        i_rst = 1'b1;
        @(negedge clk);
        ntests++;
        if (o_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_release_ready: got %b expected 1", o_ready);
        end
        exp_words = 0;
    endtask

    task automatic test_single();
        logic [23:0] w;
        w = 24'hA5C3F0;
        iv_din = w; i_din_valid = 1'b1; i_ready = 1'b1;
        ntests++;
        if (o_ready !== 1'b1) begin
            nfail++;
            $display("FAIL single_ready: got %b expected 1", o_ready);
        end
        @(negedge clk);
        i_din_valid = 1'b0;
        ntests++;
        if (o_dout_valid !== 1'b0 || o_busy !== 1'b1) begin
            nfail++;
            $display("FAIL single_latency: got valid=%b busy=%b expected valid=0 busy=1", o_dout_valid, o_busy);
        end
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== w[23-i]) begin
                nfail++;
                $display("FAIL single_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, w[23-i]);
            end
            @(negedge clk);
        end
        exp_words++;
        ntests++;
        if (o_dout_valid !== 1'b0 || o_busy !== 1'b0 || ov_words_sent !== 16'(exp_words)) begin
            nfail++;
            $display("FAIL single_end: got valid=%b busy=%b sent=%0d expected 0 0 %0d",
                     o_dout_valid, o_busy, ov_words_sent, exp_words);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] s;
        s = {24'hFFFFFF, 24'h000001};
        i_ready = 1'b1;
        iv_din = 24'hFFFFFF; i_din_valid = 1'b1;
        @(negedge clk);
        iv_din = 24'h000001;
        ntests++;
        if (o_ready !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_ready: got %b expected 1", o_ready);
        end
        @(negedge clk);
        i_din_valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i == 24) begin
                ntests++;
                if (ov_words_sent !== 16'(exp_words + 1)) begin
                    nfail++;
                    $display("FAIL b2b_count1: got %0d expected %0d", ov_words_sent, exp_words + 1);
                end
            end
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== s[47-i]) begin
                nfail++;
                $display("FAIL b2b_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, s[47-i]);
            end
            @(negedge clk);
        end
        exp_words += 2;
        ntests++;
        if (o_dout_valid !== 1'b0 || ov_words_sent !== 16'(exp_words)) begin
            nfail++;
            $display("FAIL b2b_end: got valid=%b sent=%0d expected 0 %0d", o_dout_valid, ov_words_sent, exp_words);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] w;
        w = 24'h800000;
        i_ready = 1'b1;
        iv_din = w; i_din_valid = 1'b1;
        @(negedge clk);
        i_din_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== w[23-i]) begin
                nfail++;
                $display("FAIL bp_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, w[23-i]);
            end
            @(negedge clk);
        end
        i_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== 1'b0) begin
                nfail++;
                $display("FAIL bp_hold%0d: got valid=%b dout=%b expected valid=1 dout=0", s, o_dout_valid, o_dout);
            end
        end
        i_ready = 1'b1;
        for (int i = 7; i < 24; i++) begin
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== w[23-i]) begin
                nfail++;
                $display("FAIL bp_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, w[23-i]);
            end
            @(negedge clk);
        end
        exp_words++;
        ntests++;
        if (o_dout_valid !== 1'b0 || ov_words_sent !== 16'(exp_words)) begin
            nfail++;
            $display("FAIL bp_end: got valid=%b sent=%0d expected 0 %0d", o_dout_valid, ov_words_sent, exp_words);
        end
    endtask

    task automatic test_fifo_full();
        logic [23:0]  wtab [6];
        logic [119:0] stream;
        logic         exp_rdy;
        int           nbits;
        wtab[0] = 24'hC0FFEE; wtab[1] = 24'h123456; wtab[2] = 24'h654321;
        wtab[3] = 24'hABCDEF; wtab[4] = 24'h0F0F0F; wtab[5] = 24'hDEAD00;
        i_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            iv_din = wtab[i]; i_din_valid = 1'b1;
            exp_rdy = (i < 5);
            ntests++;
            if (o_ready !== exp_rdy) begin
                nfail++;
                $display("FAIL full_ready%0d: got %b expected %b", i, o_ready, exp_rdy);
            end
            @(negedge clk);
        end
        i_din_valid = 1'b0;
        ntests++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1 || o_dout_valid !== 1'b1) begin
            nfail++;
            $display("FAIL full_state: got ready=%b busy=%b valid=%b expected 0 1 1", o_ready, o_busy, o_dout_valid);
        end
        i_ready = 1'b1;
        stream = '0;
        nbits = 0;
        for (int c = 0; c < 400 && nbits < 120; c++) begin
            if (o_dout_valid === 1'b1) begin
                stream = {stream[118:0], o_dout};
                nbits++;
            end
            @(negedge clk);
        end
        ntests++;
        if (nbits != 120) begin
            nfail++;
            $display("FAIL full_timeout: got %0d bits expected 120", nbits);
        end
        for (int k = 0; k < 5; k++) begin
            ntests++;
            if (stream[119-24*k -: 24] !== wtab[k]) begin
                nfail++;
                $display("FAIL full_word%0d: got %06h expected %06h", k, stream[119-24*k -: 24], wtab[k]);
            end
        end
        repeat (4) @(negedge clk);
        exp_words += 5;
        ntests++;
        if (o_dout_valid !== 1'b0 || o_busy !== 1'b0 || ov_words_sent !== 16'(exp_words)) begin
            nfail++;
            $display("FAIL full_end: got valid=%b busy=%b sent=%0d expected 0 0 %0d",
                     o_dout_valid, o_busy, ov_words_sent, exp_words);
        end
    endtask

    task automatic test_reset_midword();
        logic [23:0] w;
        w = 24'h123456;
        i_ready = 1'b0;
        iv_din = w;         i_din_valid = 1'b1; @(negedge clk);
        iv_din = 24'h0AAAAA;                    @(negedge clk);
        iv_din = 24'h055555;                    @(negedge clk);
        i_din_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== w[23-i]) begin
                nfail++;
                $display("FAIL rst_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, w[23-i]);
            end
            @(negedge clk);
        end
        i_rst = 1'b0;
        @(negedge clk);
        ntests++;
        if (o_dout_valid !== 1'b0 || o_ready !== 1'b0 || o_busy !== 1'b0 || ov_words_sent !== 16'd0) begin
            nfail++;
            $display("FAIL rst_mid_state: got valid=%b ready=%b busy=%b sent=%0d expected 0 0 0 0",
                     o_dout_valid, o_ready, o_busy, ov_words_sent);
        end
        i_rst = 1'b1;
        @(negedge clk);
        ntests++;
        if (o_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid_ready: got %b expected 1", o_ready);
        end
        for (int c = 0; c < 30; c++) begin
            ntests++;
            if (o_dout_valid !== 1'b0) begin
                nfail++;
                $display("FAIL rst_stale%0d: got valid=%b expected 0", c, o_dout_valid);
            end
            @(negedge clk);
        end
        exp_words = 0;
    endtask

    task automatic test_enable();
        logic [23:0] w;
        w = 24'hABCDEF;
        i_ready = 1'b1;
        iv_din = w; i_din_valid = 1'b1;
        @(negedge clk);
        i_din_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== w[23-i]) begin
                nfail++;
                $display("FAIL en_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, w[23-i]);
            end
            @(negedge clk);
        end
        for (int s = 0; s < 3; s++) begin
            i_en = 1'b0;
            @(negedge clk);
            ntests++;
            if (o_dout_valid !== 1'b0 || o_ready !== 1'b0) begin
                nfail++;
                $display("FAIL en_off%0d: got valid=%b ready=%b expected 0 0", s, o_dout_valid, o_ready);
            end
        end
        i_en = 1'b1;
        #1;
        ntests++;
        if (o_dout_valid !== 1'b1 || o_dout !== w[11]) begin
            nfail++;
            $display("FAIL en_resume: got valid=%b dout=%b expected valid=1 dout=%b", o_dout_valid, o_dout, w[11]);
        end
        for (int i = 12; i < 24; i++) begin
            ntests++;
            if (o_dout_valid !== 1'b1 || o_dout !== w[23-i]) begin
                nfail++;
                $display("FAIL en_bit%0d: got valid=%b dout=%b expected valid=1 dout=%b",
                         i, o_dout_valid, o_dout, w[23-i]);
            end
            @(negedge clk);
        end
        exp_words++;
        ntests++;
        if (o_dout_valid !== 1'b0 || ov_words_sent !== 16'(exp_words)) begin
            nfail++;
            $display("FAIL en_end: got valid=%b sent=%0d expected 0 %0d", o_dout_valid, ov_words_sent, exp_words);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_fifo_full();
        test_reset_midword();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/serial_stream_source.md
Name: serial_stream_source

Overview:
- Stimulus-side transmitter for the FIR serial link: accepts parallel samples, buffers them in a small FIFO, and shifts them out MSB-first on the 1-bit serial bus that feeds the filter chain's serial input.
- Serial side obeys the same valid/ready bit handshake as the chain's serial ports. Words are back-to-back LENGTH-bit groups with no framing bits.
- Sits on the upstream side of the deserializer. Used on the FPGA test harness and in system benches.

Parameters:
- LENGTH, 24, bits per word; also the width of iv_din.
- DEPTH, 4, FIFO entries; power of 2, 2..16.
- CNT_WIDTH, 16, width of the sent-word counter.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_en  in  1  global enable; 0 freezes all state.
- iv_din  in  LENGTH  parallel sample to transmit.
- i_din_valid  in  1  iv_din is valid.
- o_ready  out  1  FIFO can accept a word this cycle.
- o_dout  out  1  serial data bit, MSB first.
- o_dout_valid  out  1  o_dout is valid.
- i_ready  in  1  downstream accepts a serial bit this cycle.
- ov_words_sent  out  CNT_WIDTH  count of fully transmitted words.
- o_busy  out  1  FIFO non-empty or shifter active.

Behaviour:
Reset (i_rst=0 at an edge):
- FIFO is emptied; pointers are zeroed.
- State goes to IDLE and the bit counter to 0.
- Output values: o_dout=0, o_dout_valid=0, o_ready=0, ov_words_sent=0, o_busy=0.
- A mid-word reset discards the partial word and all buffered words; no remaining bits are emitted.

Enable:
- While i_en=0: o_ready=0 and o_dout_valid=0, and no state, pointer or counter changes.
- o_dout holds its last value.

Word accept:
- A word is accepted when i_din_valid & o_ready at the edge; it is written to the FIFO tail.
- o_ready = i_en & rst-released & !full. A full FIFO blocks writes even if a pop happens in the same cycle.

Shifter FSM, IDLE:
- o_dout_valid=0.
- If the FIFO is non-empty: pop the head into the shift register, clear the bit counter, go to SHIFT.
- There is no bypass: a word written to an empty FIFO at edge N is loaded at edge N+1. Its first bit is valid after edge N+1.
- Accept-to-first-bit latency is therefore 2 cycles.

Shifter FSM, SHIFT:
- o_dout_valid=1 and o_dout = shift_reg[LENGTH-1].
- On a bit transfer (o_dout_valid & i_ready):
  - shift left by 1;
  - increment the bit counter.
- On the transfer of bit LENGTH-1:
  - increment ov_words_sent, wrapping at 2^CNT_WIDTH;
  - if the FIFO is non-empty, pop and load the next word at the same edge and stay in SHIFT with counter 0, giving zero bubble between words;
  - otherwise go to IDLE.
- i_ready=0 holds o_dout and o_dout_valid stable until accepted. o_dout must not change while valid and unaccepted.

Simultaneous events:
- A FIFO write and pop in the same cycle are both performed; occupancy is unchanged.
- A write while empty and IDLE is not visible to the pop until the next edge.

Pointers and flags:
- Pointers are log2(DEPTH) bits and wrap naturally.
- Full/empty use an extra occupancy counter 0..DEPTH.

Status:
- o_busy = (count!=0) | (state==SHIFT).
- All outputs are registered except o_ready, o_dout_valid and o_busy, which are combinational from registers and i_en.

Test Plan:
- Single word, LENGTH=24, i_ready=1. Write 0xA5C3F0 at cycle 0 -> o_dout_valid rises after edge 1. The 24 bits are 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1,1,1,1,1,0,0,0,0 on consecutive cycles. ov_words_sent=1 after the last bit, then IDLE with o_busy=0.
- Back-to-back words. Write 0xFFFFFF then 0x000001 on consecutive cycles, i_ready=1 -> 48 contiguous valid bits with no bubble; the bit after 24 ones is the first 0. ov_words_sent goes 1 then 2.
- Backpressure. Hold i_ready=0 for 5 cycles at bit 7 of 0x800000 -> o_dout stays 0 and o_dout_valid stays 1 throughout. Transmission resumes with bit 7 and the total is still exactly 24 transfers.
- FIFO full. With i_ready=0, write 6 words while DEPTH=4 -> one word in the shifter plus 4 buffered. o_ready=0 afterwards and the 6th write is refused. Release i_ready -> exactly 5 words come out in order.
- Reset mid-word. Assert i_rst=0 after 10 bits of 0x123456 with 2 words queued -> next cycle o_dout_valid=0, o_ready=0, ov_words_sent=0, o_busy=0. After release, o_ready=1 and no stale bits are emitted.
- Enable gating. Drop i_en for 3 cycles at bit 12 -> o_dout_valid=0 and no bit is lost. Once i_en returns, bit 12 is presented and the word totals 24 bits.
